// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the HI/LO multiply/divide unit.
// Operation codes, FSM state type and small op-class decoders.
// Optional feature macro: MDU_MACC_EN (enables MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

   // Operation encodings presented on the op input.
   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
   localparam logic [3:0] OP_MADD  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd7;
   localparam logic [3:0] OP_MSUB  = 4'd8;
   localparam logic [3:0] OP_MSUBU = 4'd9;

   // Sequencer states: waiting for a request, or counting down a long op.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   // Ops that take the multiply latency (accumulates share the multiplier).
   function automatic logic is_mul_op(input logic [3:0] op);
      logic r;
      r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MACC_EN
      r = r || (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
`endif
      return r;
   endfunction

   // Ops that take the divide latency.
   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Single-edge register writes that never raise busy.
   function automatic logic is_move_op(input logic [3:0] op);
      return (op == OP_MTHI) || (op == OP_MTLO);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational result generator for the multiply/divide unit.
// Given op, operands and the current {hi,lo}, returns the next {hi,lo}.
// Undefined codes return the current {hi,lo} unchanged.
// Optional feature macro: MDU_MACC_EN (adds the accumulate adder).
module mdu_arith
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

   logic signed [2*WIDTH-1:0] prod_s;
   logic        [2*WIDTH-1:0] prod_u;
   logic signed [WIDTH-1:0]   a_s;
   logic signed [WIDTH-1:0]   b_s;
   logic signed [WIDTH-1:0]   quo_s;
   logic signed [WIDTH-1:0]   rem_s;
   logic        [WIDTH-1:0]   quo_u;
   logic        [WIDTH-1:0]   rem_u;
   logic                      div_zero;
   logic                      div_ovf;
   logic        [2*WIDTH-1:0] res;

   assign a_s = $signed(a);
   assign b_s = $signed(b);

   // Operands are widened explicitly so the 2*WIDTH product is exact.
   assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   assign div_zero = (b == ZERO);
   assign div_ovf  = (a == INT_MIN) && (b == ALL_ONE);

   // Raw quotients/remainders; the zero and overflow cases are overridden below.
   always_comb begin
      quo_s = a_s / b_s;
      rem_s = a_s % b_s;
      quo_u = a / b;
      rem_u = a % b;
   end

   // Select the next {hi,lo} for the requested op.
   always_comb begin
      res = {hi, lo};
      case (op)
         OP_MULT:  res = $unsigned(prod_s);
         OP_MULTU: res = prod_u;
         OP_DIV: begin
            if (div_zero)     res = {a, ALL_ONE};
            else if (div_ovf) res = {ZERO, INT_MIN};
            else              res = {$unsigned(rem_s), $unsigned(quo_s)};
         end
         OP_DIVU: begin
            if (div_zero) res = {a, ALL_ONE};
            else          res = {rem_u, quo_u};
         end
         OP_MTHI:  res = {a, lo};
         OP_MTLO:  res = {hi, a};
`ifdef MDU_MACC_EN
         OP_MADD:  res = {hi, lo} + $unsigned(prod_s);
         OP_MADDU: res = {hi, lo} + prod_u;
         OP_MSUB:  res = {hi, lo} - $unsigned(prod_s);
         OP_MSUBU: res = {hi, lo} - prod_u;
`endif
         default:  res = {hi, lo};
      endcase
   end

   assign res_hi = res[2*WIDTH-1:WIDTH];
   assign res_lo = res[WIDTH-1:0];

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multiply/divide unit with HI/LO registers for the EX stage.
// Long ops latch their result into pending registers at issue and commit
// it to hi/lo after MULT_CYCLES or DIV_CYCLES; busy covers that window.
// Optional feature macro: MDU_MACC_EN (MADD/MADDU/MSUB/MSUBU).
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] phi_q, phi_d;
   logic [WIDTH-1:0] plo_q, plo_d;
   logic [WIDTH-1:0] arith_hi;
   logic [WIDTH-1:0] arith_lo;

   // The accumulate ops read hi_q/lo_q, i.e. the value at the start edge.
   mdu_arith #(
      .WIDTH (WIDTH)
   ) u_arith (
      .op     (op),
      .a      (a),
      .b      (b),
      .hi     (hi_q),
      .lo     (lo_q),
      .res_hi (arith_hi),
      .res_lo (arith_lo)
   );

   // Next-state logic: accept requests in IDLE, count down and commit in RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (is_mul_op(op)) begin
                  phi_d   = arith_hi;
                  plo_d   = arith_lo;
                  cnt_d   = MUL_LAT;
                  state_d = ST_RUN;
               end else if (is_div_op(op)) begin
                  phi_d   = arith_hi;
                  plo_d   = arith_lo;
                  cnt_d   = DIV_LAT;
                  state_d = ST_RUN;
               end else if (is_move_op(op)) begin
                  hi_d = arith_hi;
                  lo_d = arith_lo;
               end
            end
         end
         ST_RUN: begin
            // start is deliberately ignored here: no queueing.
            if (cnt_q == CNT_ONE) begin
               hi_d    = phi_q;
               lo_d    = plo_q;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and data registers; reset also discards any in-flight result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Parametrised multiply/divide unit with HI/LO result registers for the pipelined MIPS core. It sits beside the ALU in the EX stage and executes mult/multu/div/divu and mthi/mtlo with configurable multi-cycle latency. While an operation is in flight it raises `busy`; the controller uses `start | busy` to stall any HI/LO-touching instruction in D. The optional accumulate ops extend the original fixed ALU-only datapath.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 2.
- `MULT_CYCLES`, 5: cycles from an accepted multiply to its result; must be ≥ 1.
- `DIV_CYCLES`, 10: cycles from an accepted divide to its result; must be ≥ 1.

- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: one-cycle request qualifier, sampled on the rising edge.
- `op` input, 4 bits: operation code; encodings are listed in Structure.
- `a` input, `WIDTH` bits: operand rs.
- `b` input, `WIDTH` bits: operand rt.
- `busy` output, 1 bit: a multiply or divide is in flight.
- `hi` output, `WIDTH` bits: HI register value.
- `lo` output, `WIDTH` bits: LO register value.

## Operation
- **States:** IDLE and RUN. A 0..max(MULT_CYCLES, DIV_CYCLES) counter runs in RUN.
- **IDLE, `start`=1:**
  - MULT/MULTU/DIV/DIVU: compute the result from `a`/`b` into pending registers, load the counter with the op latency, go to RUN.
  - MTHI: `hi`←`a` at this edge; stay in IDLE.
  - MTLO: `lo`←`a` at this edge; stay in IDLE.
- **RUN:** decrement the counter each cycle. When it reaches 1, copy pending HI/LO into `hi`/`lo` and return to IDLE on the same edge.
- **`start` while in RUN:** ignored entirely. There is no queueing and no effect on `hi`/`lo`; the controller must never do this.
- **Undefined `op` codes with `start`:** no effect.
- **Multiply:** full 2·WIDTH product; `hi` gets the upper half, `lo` the lower half. MULT is signed, MULTU is unsigned.
- **Divide:** `lo` = quotient truncated toward zero; `hi` = remainder, which takes the sign of the dividend. DIV is signed, DIVU is unsigned.
- **Divide by zero (`b`=0):** `lo` = all ones, `hi` = `a`. Applies to signed and unsigned.
- **Signed overflow (DIV, `a`=INT_MIN, `b`=−1):** `lo` = INT_MIN, `hi` = 0.
- **Reset (async, any state, including mid-operation):**
  - `busy`=0, state IDLE, counter 0.
  - `hi`=0, `lo`=0, pending registers 0.
  - Any in-flight result is discarded.

## Timing
- **Multiply/divide accepted at edge T0:**
  - `busy`=1 after T0 through edge T0+N, where N is MULT_CYCLES or DIV_CYCLES. That is exactly N cycles high.
  - `hi`/`lo` change at edge T0+N, on the same edge `busy` falls.
- **Back-to-back:** a new `start` is legal in the first cycle `busy`=0, i.e. it is sampled at edge T0+N+1.
- **Stall hazard:** `busy` is registered. The controller must combine it with `start` to cover the issue cycle.
- **MTHI/MTLO:** single-edge write, `busy` is never asserted, and the new value is readable in the following cycle.
- **Read visibility:** `hi`/`lo` are direct register outputs with no bypass. A value written at edge E is visible only after E.

## Configuration
- Macro `MDU_MACC_EN`.
- **Defined:** op codes MADD, MADDU, MSUB, MSUBU are accepted with MULT_CYCLES latency.
  - Result is {hi,lo} ± product (signed or unsigned as the op names).
  - The 2·WIDTH sum/difference wraps modulo 2^(2·WIDTH).
  - The {hi,lo} operand is the value sampled at the start edge.
- **Undefined:** these codes behave like any undefined `op` (no effect). No accumulate adder is synthesised.

## Structure
- **Package `mdu_pkg`:** holds the `op` encodings as constants.
  - MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - MADD=6, MADDU=7, MSUB=8, MSUBU=9.
  - Also holds the state enum (IDLE, RUN).
- **Sub-module `mdu_arith`:** combinational only. Takes `op`, `a`, `b` and current {hi,lo}; produces the next {hi,lo} pair, including the div-by-zero, overflow and accumulate rules. `mdu_unit` holds the FSM, counter and registers.

## Test plan
- **Signed multiply:** reset, then MULT `a`=−3 (0xFFFFFFFD), `b`=7 → `busy` high for exactly 5 cycles; `hi`=0xFFFFFFFF and `lo`=0xFFFFFFEB at the edge `busy` falls.
- **Signed divide:** DIV `a`=−7, `b`=2 → after 10 cycles `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). Then DIVU `a`=7, `b`=0 → `lo`=0xFFFFFFFF, `hi`=7.
- **Signed overflow:** DIV `a`=0x80000000, `b`=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Move ops and ignored start:** MTHI `a`=0x1234 → `hi`=0x1234 the next cycle with `busy` never high. A MULT issued in cycle 2 of a running DIV is ignored: only the DIV result appears, at T0+10.
- **Reset mid-operation:** assert `reset` asynchronously in cycle 3 of a MULTU → `busy`, `hi` and `lo` go to 0 immediately. The pending result never appears after reset is released.
- **Accumulate (`MDU_MACC_EN` defined):** with {hi,lo}={0,0xFFFFFFFF}, MADDU `a`=1, `b`=1 → {hi,lo}={1,0}. Without the macro, the same op leaves {hi,lo} unchanged and `busy` stays 0.
